boot_loader: RTL and testbench
==============================

Name: boot_loader

Overview:
- Synthesizable loader that runs before the CPU core leaves reset.
- Accepts a beat stream of program/data words and writes it into instruction and data memory.
- Keeps the core held in reset until the whole image is loaded, then releases it.
- Sits directly upstream of the CPU top: it feeds the memories the core fetches from and drives the core's reset.

Parameters:
- IMEM_AW, 10, instruction-memory word-address width.
- DMEM_AW, 10, data-memory word-address width.
- RELEASE_DLY, 4, cycles from entering DONE to deasserting cpu_reset (range 1..15).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- s_valid  in  1  input beat valid.
- s_ready  out  1  loader can accept a beat.
- s_data  in  32  header or payload word.
- s_last  in  1  final beat of the whole image.
- imem_we  out  1  instruction-memory write strobe.
- dmem_we  out  1  data-memory write strobe.
- mem_addr  out  16  word address, shared by both memories.
- mem_wdata  out  32  write data.
- cpu_reset  out  1  reset to the CPU top, active-high.
- done  out  1  image loaded without error.
- error  out  1  protocol violation detected.
- checksum  out  32  running XOR of all accepted payload words.

Behaviour:
- Beat accepted when s_valid && s_ready.
- Reset values: s_ready=0, imem_we=0, dmem_we=0, mem_addr=0, mem_wdata=0, cpu_reset=1, done=0, error=0, checksum=0. States are HDR, DATA, DONE, ERR; reset enters HDR.
- s_ready is 1 in HDR, DATA and ERR, and 0 in DONE. It is registered and goes to 1 on the first clock after reset deasserts.
- Header word layout: bit31 is the region (0=imem, 1=dmem), bits 30:16 are the count N, bits 15:0 are the base word address.
- HDR, header accepted, transition order:
  - If s_last=1, or N=0, or base has any bit set at or above the region's AW, go to ERR.
  - Otherwise latch region, N and base; clear the index; go to DATA.
- DATA, payload beat accepted:
  - Registered write on the next cycle: we of the latched region =1 for exactly 1 cycle.
  - mem_addr = (base+index) modulo 2^AW of that region, zero-extended to 16 bits.
  - mem_wdata = s_data. checksum ^= s_data, updated in the same cycle as the write strobe.
  - index increments.
- DATA exit rules:
  - Final beat (index==N-1) with s_last=1: go to DONE.
  - Final beat with s_last=0: go to HDR (next segment).
  - Non-final beat with s_last=1: go to ERR; that beat is still written.
- Write latency: exactly 1 cycle from acceptance to strobe. Back-to-back beats give a strobe every cycle. At most one of imem_we/dmem_we is high at any time.
- DONE:
  - done=1 from the cycle after entry.
  - cpu_reset deasserts exactly RELEASE_DLY cycles after entry and stays 0.
  - A stalled s_valid in DONE is ignored.
- ERR:
  - error=1 from the cycle after entry; cpu_reset stays 1; done stays 0.
  - Beats are accepted and discarded: no writes, checksum frozen.
  - Sticky until reset.
- Reset asserted mid-load: all outputs return to reset values immediately (asynchronous). Memory contents already written are not rolled back.
- mem_addr and mem_wdata hold their last value when no strobe is active.

Decomposition:
- Package boot_loader_pkg holds:
  - state enum: HDR, DATA, DONE, ERR.
  - region constants: REG_IMEM=0, REG_DMEM=1.
  - header field bit positions: HDR_REGION_BIT=31, HDR_CNT_MSB=30, HDR_CNT_LSB=16, HDR_BASE_MSB=15.
  - packed struct for the decoded header.
- One sub-module, boot_release_timer: a counter loaded on DONE entry that drives cpu_reset low after RELEASE_DLY cycles. All other logic stays in boot_loader.

Test Plan:
- Single imem segment: header 0x0003_0010, then payload 0xA, 0xB, 0xC with s_last on 0xC. Expect imem_we pulses at addresses 0x10, 0x11, 0x12 with data 0xA/0xB/0xC; checksum=0xD; done=1; cpu_reset falls 4 cycles after DONE entry.
- Two segments with stalls: imem header 0x0002_0000 with 2 words, then dmem header 0x8001_0005 with 1 word and s_last. Toggle s_valid randomly. Expect dmem_we once at address 5, no dmem_we during segment 1, done=1.
- Wrap-around: header 0x0002_03FF (IMEM_AW=10), two words, s_last. Expect writes at addresses 0x3FF then 0x000.
- Early s_last: header 0x0004_0000, s_last on the 2nd word. Expect 2 writes, error=1, cpu_reset stays 1, later beats produce no writes.
- Bad headers, each starting from a fresh reset: count=0 (0x0000_0000); base out of range (0x0001_0400); s_last on a header. Each gives error=1 with no write strobes.
- Reset mid-load: assert reset after 1 of 3 payload words. Expect immediate reset values (cpu_reset=1, checksum=0). A complete reload afterwards then reaches done=1.

Source files
------------

// File: rtl/boot_loader_pkg.sv
// Shared types and header-field layout for the boot-time image loader.
// The header decoder and address-mask helper are used by boot_loader.
package boot_loader_pkg;

    typedef enum logic [1:0] {
        HDR  = 2'd0,
        DATA = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_e;

    localparam logic REG_IMEM = 1'b0;
    localparam logic REG_DMEM = 1'b1;

    localparam int HDR_REGION_BIT = 31;
    localparam int HDR_CNT_MSB    = 30;
    localparam int HDR_CNT_LSB    = 16;
    localparam int HDR_BASE_MSB   = 15;

    typedef struct packed {
        logic        region;
        logic [14:0] count;
        logic [15:0] base;
    } hdr_t;

    function automatic hdr_t decode_hdr(input logic [31:0] w);
        hdr_t h;
        h.region = w[HDR_REGION_BIT];
        h.count  = w[HDR_CNT_MSB:HDR_CNT_LSB];
        h.base   = w[HDR_BASE_MSB:0];
        return h;
    endfunction

    // Low-aw-bits mask; valid for aw in 1..16.
    function automatic logic [15:0] aw_mask(input int unsigned aw);
        logic [31:0] m;
        m = (32'h0000_0001 << aw) - 32'h0000_0001;
        return m[15:0];
    endfunction

endpackage

// File: rtl/boot_release_timer.sv
// Holds the CPU in reset and releases it a fixed number of cycles after the
// loader signals DONE entry; once released it stays released until reset.
module boot_release_timer #(
    parameter int RELEASE_DLY = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic cpu_reset
);

    localparam logic [3:0] LOAD_VAL = 4'(RELEASE_DLY - 1);

    logic [3:0] cnt_q, cnt_d;
    logic       run_q, run_d;
    logic       cpu_reset_q, cpu_reset_d;

    // Next-state: load on start, count down, drop cpu_reset on reaching zero.
    always_comb begin
        cnt_d       = cnt_q;
        run_d       = run_q;
        cpu_reset_d = cpu_reset_q;
        if (start) begin
            cnt_d = LOAD_VAL;
            run_d = 1'b1;
        end else if (run_q) begin
            if (cnt_q == 4'd0) begin
                run_d       = 1'b0;
                cpu_reset_d = 1'b0;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Timer state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q       <= 4'd0;
            run_q       <= 1'b0;
            cpu_reset_q <= 1'b1;
        end else begin
            cnt_q       <= cnt_d;
            run_q       <= run_d;
            cpu_reset_q <= cpu_reset_d;
        end
    end

    assign cpu_reset = cpu_reset_q;

endmodule

// File: rtl/boot_loader.sv
// Boot-time loader: parses header/payload beats into imem/dmem writes and
// holds the CPU in reset until the full image has landed without error.
module boot_loader
    import boot_loader_pkg::*;
#(
    parameter int IMEM_AW     = 10,
    parameter int DMEM_AW     = 10,
    parameter int RELEASE_DLY = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [31:0] s_data,
    input  logic        s_last,
    output logic        imem_we,
    output logic        dmem_we,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_reset,
    output logic        done,
    output logic        error,
    output logic [31:0] checksum
);

    state_e      state_q, state_d;
    logic        region_q, region_d;
    logic [14:0] cnt_q, cnt_d;
    logic [14:0] idx_q, idx_d;
    logic [15:0] base_q, base_d;
    logic        s_ready_q, s_ready_d;
    logic        imem_we_q, imem_we_d;
    logic        dmem_we_q, dmem_we_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] checksum_q, checksum_d;
    logic        done_q, done_d;
    logic        error_q, error_d;

    hdr_t        hdr_s;
    logic        accept_s;
    logic [15:0] hdr_mask_s;
    logic        base_ok_s;
    logic [15:0] seg_mask_s;
    logic        last_idx_s;
    logic        release_start_s;

    assign hdr_s      = decode_hdr(s_data);
    assign accept_s   = s_valid && s_ready_q;
    assign hdr_mask_s = (hdr_s.region == REG_DMEM) ? aw_mask(DMEM_AW) : aw_mask(IMEM_AW);
    assign base_ok_s  = ((hdr_s.base & ~hdr_mask_s) == 16'h0000);
    assign seg_mask_s = (region_q == REG_DMEM) ? aw_mask(DMEM_AW) : aw_mask(IMEM_AW);
    assign last_idx_s = (idx_q == (cnt_q - 15'd1));

    // Loader FSM next-state and registered-output computation.
    always_comb begin
        state_d     = state_q;
        region_d    = region_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        base_d      = base_q;
        imem_we_d   = 1'b0;
        dmem_we_d   = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        checksum_d  = checksum_q;
        case (state_q)
            HDR: begin
                if (accept_s) begin
                    if (s_last || (hdr_s.count == 15'd0) || !base_ok_s) begin
                        state_d = ERR;
                    end else begin
                        region_d = hdr_s.region;
                        cnt_d    = hdr_s.count;
                        base_d   = hdr_s.base;
                        idx_d    = 15'd0;
                        state_d  = DATA;
                    end
                end else begin
                    state_d = HDR;
                end
            end
            DATA: begin
                if (accept_s) begin
                    imem_we_d   = (region_q == REG_IMEM);
                    dmem_we_d   = (region_q == REG_DMEM);
                    mem_addr_d  = (base_q + {1'b0, idx_q}) & seg_mask_s;
                    mem_wdata_d = s_data;
                    checksum_d  = checksum_q ^ s_data;
                    idx_d       = idx_q + 15'd1;
                    // A short image still writes its final beat before erroring.
                    if (last_idx_s) begin
                        state_d = s_last ? DONE : HDR;
                    end else if (s_last) begin
                        state_d = ERR;
                    end else begin
                        state_d = DATA;
                    end
                end else begin
                    state_d = DATA;
                end
            end
            DONE:    state_d = DONE;
            ERR:     state_d = ERR;
            default: state_d = ERR;
        endcase
    end

    assign s_ready_d       = (state_d != DONE);
    assign done_d          = (state_q == DONE);
    assign error_d         = (state_q == ERR);
    assign release_start_s = (state_d == DONE) && (state_q != DONE);

    // Loader state and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= HDR;
            region_q    <= REG_IMEM;
            cnt_q       <= 15'd0;
            idx_q       <= 15'd0;
            base_q      <= 16'h0000;
            s_ready_q   <= 1'b0;
            imem_we_q   <= 1'b0;
            dmem_we_q   <= 1'b0;
            mem_addr_q  <= 16'h0000;
            mem_wdata_q <= 32'h0000_0000;
            checksum_q  <= 32'h0000_0000;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            region_q    <= region_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            base_q      <= base_d;
            s_ready_q   <= s_ready_d;
            imem_we_q   <= imem_we_d;
            dmem_we_q   <= dmem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            checksum_q  <= checksum_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    boot_release_timer #(
        .RELEASE_DLY (RELEASE_DLY)
    ) u_release_timer (
        .clk       (clk),
        .reset     (reset),
        .start     (release_start_s),
        .cpu_reset (cpu_reset)
    );

    assign s_ready   = s_ready_q;
    assign imem_we   = imem_we_q;
    assign dmem_we   = dmem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign checksum  = checksum_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: write strobes are logged at the falling
// edge and checked against hand-computed addresses, data and flags.
module tb_boot_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        s_last;
    logic        imem_we;
    logic        dmem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_reset;
    logic        done;
    logic        error;
    logic [31:0] checksum;

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] log_addr[$];
    logic [31:0] log_data[$];
    logic        log_dm[$];
    int          both_cnt = 0;

    boot_loader #(
        .IMEM_AW     (10),
        .DMEM_AW     (10),
        .RELEASE_DLY (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .imem_we   (imem_we),
        .dmem_we   (dmem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_reset (cpu_reset),
        .done      (done),
        .error     (error),
        .checksum  (checksum)
    );

    always #5 clk = ~clk;

    // Write-strobe logger.
    always @(negedge clk) begin
        if (imem_we || dmem_we) begin
            log_addr.push_back(mem_addr);
            log_data.push_back(mem_wdata);
            log_dm.push_back(dmem_we);
        end
        if (imem_we && dmem_we) both_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        s_valid = 1'b0;
        s_data  = 32'h0;
        s_last  = 1'b0;
        repeat (2) @(negedge clk);
        log_addr.delete();
        log_data.delete();
        log_dm.delete();
        chk("rst_ready", {31'd0, s_ready}, 32'd0);
        chk("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        chk("rst_we", {30'd0, imem_we, dmem_we}, 32'd0);
        chk("rst_addr", {16'd0, mem_addr}, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_flags", {30'd0, done, error}, 32'd0);
        chk("rst_checksum", checksum, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("ready_low_after_rst", {31'd0, s_ready}, 32'd0);
        @(negedge clk);
        chk("ready_high", {31'd0, s_ready}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    // Present one beat and hold it until accepted; returns at accept edge + 1.
    task automatic send(input logic [31:0] d, input logic l, input int gap);
        bit ok;
        s_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (s_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1 s_valid = 1'b0;
        s_last = 1'b0;
    endtask

    task automatic wait_done();
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done) break;
        end
        chk("done_reached", {31'd0, done}, 32'd1);
    endtask

    initial begin
        // Single imem segment with release timing.
        do_reset();
        send(32'h0003_0010, 1'b0, 0);
        send(32'h0000_000A, 1'b0, 0);
        send(32'h0000_000B, 1'b0, 0);
        send(32'h0000_000C, 1'b1, 0);
        chk("t1_checksum", checksum, 32'h0000_000D);
        chk("t1_done_not_yet", {31'd0, done}, 32'd0);
        chk("t1_ready_done", {31'd0, s_ready}, 32'd0);
        chk("t1_cpu_reset_held", {31'd0, cpu_reset}, 32'd1);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            chk("t1_done", {31'd0, done}, 32'd1);
            chk("t1_cpu_reset", {31'd0, cpu_reset}, (k < 4) ? 32'd1 : 32'd0);
        end
        s_valid = 1'b1;
        s_data  = 32'hDEAD_BEEF;
        repeat (3) @(posedge clk);
        #1 s_valid = 1'b0;
        @(negedge clk);
        chk("t1_nwrites", log_addr.size(), 32'd3);
        chk("t1_a0", {16'd0, log_addr[0]}, 32'h10);
        chk("t1_a1", {16'd0, log_addr[1]}, 32'h11);
        chk("t1_a2", {16'd0, log_addr[2]}, 32'h12);
        chk("t1_d0", log_data[0], 32'hA);
        chk("t1_d1", log_data[1], 32'hB);
        chk("t1_d2", log_data[2], 32'hC);
        chk("t1_imem", {29'd0, log_dm[0], log_dm[1], log_dm[2]}, 32'd0);
        chk("t1_checksum_frozen", checksum, 32'h0000_000D);
        chk("t1_cpu_reset_stays", {31'd0, cpu_reset}, 32'd0);

        // Two segments with random stalls.
        do_reset();
        send(32'h0002_0000, 1'b0, int'($urandom_range(2)));
        send(32'h0000_0001, 1'b0, int'($urandom_range(2)));
        send(32'h0000_0002, 1'b0, int'($urandom_range(2)));
        send(32'h8001_0005, 1'b0, int'($urandom_range(2)));
        send(32'h0000_0003, 1'b1, int'($urandom_range(2)));
        wait_done();
        chk("t2_nwrites", log_addr.size(), 32'd3);
        chk("t2_regions", {29'd0, log_dm[0], log_dm[1], log_dm[2]}, 32'b001);
        chk("t2_a0", {16'd0, log_addr[0]}, 32'h0);
        chk("t2_a1", {16'd0, log_addr[1]}, 32'h1);
        chk("t2_dm_addr", {16'd0, log_addr[2]}, 32'h5);
        chk("t2_dm_data", log_data[2], 32'h3);
        chk("t2_checksum", checksum, 32'h0);

        // Address wrap within IMEM_AW.
        do_reset();
        send(32'h0002_03FF, 1'b0, 0);
        send(32'h0000_0011, 1'b0, 0);
        send(32'h0000_0022, 1'b1, 0);
        wait_done();
        chk("t3_nwrites", log_addr.size(), 32'd2);
        chk("t3_a0", {16'd0, log_addr[0]}, 32'h3FF);
        chk("t3_a1", {16'd0, log_addr[1]}, 32'h000);
        chk("t3_d1", log_data[1], 32'h22);

        // Early s_last.
        do_reset();
        send(32'h0004_0000, 1'b0, 0);
        send(32'h0000_0005, 1'b0, 0);
        send(32'h0000_0006, 1'b1, 0);
        @(posedge clk);
        #1;
        chk("t4_error", {31'd0, error}, 32'd1);
        send(32'h0000_0007, 1'b0, 0);
        send(32'h0000_0008, 1'b1, 0);
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("t4_nwrites", log_addr.size(), 32'd2);
        chk("t4_a1", {16'd0, log_addr[1]}, 32'h1);
        chk("t4_checksum", checksum, 32'h3);
        chk("t4_flags", {30'd0, done, error}, 32'b01);
        chk("t4_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        chk("t4_ready_err", {31'd0, s_ready}, 32'd1);

        // Bad headers.
        do_reset();
        send(32'h0000_0000, 1'b0, 0);
        send(32'h0000_0001, 1'b1, 0);
        repeat (2) @(negedge clk);
        chk("t5a_error", {31'd0, error}, 32'd1);
        chk("t5a_nwrites", log_addr.size(), 32'd0);
        do_reset();
        send(32'h0001_0400, 1'b0, 0);
        send(32'h0000_0001, 1'b1, 0);
        repeat (2) @(negedge clk);
        chk("t5b_error", {31'd0, error}, 32'd1);
        chk("t5b_nwrites", log_addr.size(), 32'd0);
        do_reset();
        send(32'h0001_0000, 1'b1, 0);
        send(32'h0000_0001, 1'b1, 0);
        repeat (2) @(negedge clk);
        chk("t5c_error", {31'd0, error}, 32'd1);
        chk("t5c_nwrites", log_addr.size(), 32'd0);
        chk("t5c_cpu_reset", {31'd0, cpu_reset}, 32'd1);

        // Reset mid-load, then full reload.
        do_reset();
        send(32'h0003_0000, 1'b0, 0);
        send(32'h0000_00AA, 1'b0, 0);
        chk("t6_pre_checksum", checksum, 32'hAA);
        chk("t6_pre_we", {31'd0, imem_we}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("t6_async_checksum", checksum, 32'd0);
        chk("t6_async_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        chk("t6_async_we", {30'd0, imem_we, dmem_we}, 32'd0);
        chk("t6_async_addr_ready", {15'd0, mem_addr, s_ready}, 32'd0);
        do_reset();
        send(32'h0001_0000, 1'b0, 0);
        send(32'h0000_0055, 1'b1, 0);
        wait_done();
        chk("t6_checksum", checksum, 32'h55);
        chk("t6_error", {31'd0, error}, 32'd0);

        chk("one_hot_we", both_cnt, 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
